// File: rtl/l_step_dispatch_hex.sv
// rtl/l_step_dispatch_hex.sv - step sequencer broadcasting start pulses to 16 diffusion PEs
// Optional per-step watchdog enabled by defining STEP_TIMEOUT_EN.
module l_step_dispatch_hex #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STEPS  = 7,
    parameter int N_PE       = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [N_PE-1:0]       pe_enable,
    input  logic                  ack,
    input  logic [N_PE-1:0]       finished,
    output logic [N_PE-1:0]       pe_start,
    output logic [DATA_WIDTH-1:0] l_step,
    output logic [DATA_WIDTH-1:0] steps_done,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } state_t;

    localparam logic [DATA_WIDTH-1:0] STEP_LAST = DATA_WIDTH'(MAX_STEPS - 1);
    localparam logic [DATA_WIDTH-1:0] STEP_ONE  = DATA_WIDTH'(1);

    state_t          state;
    state_t          state_next;
    logic [N_PE-1:0] mask;
    logic [N_PE-1:0] sticky;
    logic            go_accept;
    logic            all_done;
    logic            last_step;
    logic            wd_expire;

    assign go_accept = go && (pe_enable != '0);
    // A finish arriving in the same WAIT cycle counts; disabled PEs read as finished.
    assign all_done  = &(sticky | (finished & mask) | ~mask);
    assign last_step = (steps_done == STEP_LAST);

`ifdef STEP_TIMEOUT_EN
    localparam int             WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state == S_WAIT) && !all_done && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                wd_cnt <= '0;
            end else if ((state == S_WAIT) && !wd_expire) begin
                wd_cnt <= wd_cnt + WD_ONE;
            end

            if ((state == S_IDLE) && go_accept) begin
                timeout <= 1'b0;
            end else if (wd_expire) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (go_accept) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (all_done) begin
                    state_next = S_ADVANCE;
                end else if (wd_expire) begin
                    state_next = S_DONE;
                end
            end
            S_ADVANCE: begin
                state_next = last_step ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                if (ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status flags follow the upcoming state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_start   <= '0;
            l_step     <= '0;
            steps_done <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mask       <= '0;
            sticky     <= '0;
        end else begin
            pe_start <= (state == S_ISSUE) ? mask : '0;
            busy     <= (state_next == S_ISSUE) || (state_next == S_WAIT) ||
                        (state_next == S_ADVANCE);
            done     <= (state_next == S_DONE);

            case (state)
                S_IDLE: begin
                    if (go_accept) begin
                        mask       <= pe_enable;
                        l_step     <= '0;
                        steps_done <= '0;
                        sticky     <= '0;
                    end
                end
                S_WAIT: begin
                    sticky <= sticky | (finished & mask);
                end
                S_ADVANCE: begin
                    steps_done <= steps_done + STEP_ONE;
                    sticky     <= '0;
                    if (!last_step) begin
                        l_step <= l_step + STEP_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l_step_dispatch_hex.sv
// tb/tb_l_step_dispatch_hex.sv - directed vector and run-level checks for l_step_dispatch_hex
module tb_l_step_dispatch_hex;

    localparam int DW = 32;
    localparam int MS = 7;
    localparam int NP = 16;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic          ack;
    logic [NP-1:0] pe_enable;
    logic [NP-1:0] finished;
    logic [NP-1:0] pe_start;
    logic [DW-1:0] l_step;
    logic [DW-1:0] steps_done;
    logic          busy;
    logic          done;
    logic          timeout;

    int n_tests = 0;
    int n_fail  = 0;

    l_step_dispatch_hex #(
        .DATA_WIDTH(DW),
        .MAX_STEPS (MS),
        .N_PE      (NP),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .pe_enable (pe_enable),
        .ack       (ack),
        .finished  (finished),
        .pe_start  (pe_start),
        .l_step    (l_step),
        .steps_done(steps_done),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        go;
        logic        ack;
        logic [15:0] en;
        logic [15:0] fin;
        logic [15:0] e_start;
        logic [31:0] e_l;
        logic [31:0] e_sd;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: all finish 5 cycles after pe_start; 1: PE i at i+2; 2: PE15 first;
    // 3: finished held high; 4: bits 4-7 at cycle 3 with noise elsewhere
    task automatic do_run(input logic [15:0] m, input int mode, input int period,
                          input int tail, input int stop_step);
        int  c;
        int  pulses;
        int  last_t;
        int  t;
        bit  done_seen;
        pulses    = 0;
        c         = 1000;
        last_t    = 0;
        done_seen = 1'b0;
        finished  = (mode == 3) ? 16'hFFFF : 16'h0000;
        go        = 1'b1;
        pe_enable = m;
        tick();
        go        = 1'b0;
        pe_enable = ~m;
        for (t = 0; t < 600; t++) begin
            tick();
            if (pe_start != '0) begin
                check("pe_start_mask", 32'(pe_start), 32'(m));
                check("l_step_at_start", l_step, 32'(pulses));
                if (pulses > 0) begin
                    check("step_period", 32'(t - last_t), 32'(period));
                end
                last_t = t;
                pulses++;
                c = 0;
                if (pulses - 1 == stop_step) begin
                    return;
                end
            end else begin
                c++;
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            case (mode)
                0:       finished = (c == 5) ? 16'hFFFF : 16'h0000;
                1:       finished = (c >= 2 && c <= 17) ? 16'(1 << (c - 2)) : 16'h0000;
                2:       finished = (c >= 2 && c <= 17) ? 16'(1 << (17 - c)) : 16'h0000;
                3:       finished = 16'hFFFF;
                default: finished = (16'($urandom) & 16'hFF0F) | ((c == 3) ? 16'h00F0 : 16'h0000);
            endcase
        end
        check("done_reached", 32'(done_seen), 32'd1);
        check("done_tail", 32'(t - last_t), 32'(tail));
        check("pulse_count", 32'(pulses), 32'(MS));
        check("final_steps_done", steps_done, 32'(MS));
        check("final_l_step", l_step, 32'(MS - 1));
        check("busy_in_done", 32'(busy), 32'd0);
        check("no_timeout", 32'(timeout), 32'd0);
        finished = '0;
        ack      = 1'b1;
        tick();
        ack      = 1'b0;
        check("done_after_ack", 32'(done), 32'd0);
        check("busy_after_ack", 32'(busy), 32'd0);
    endtask

    initial begin
        //           rst   go    ack   en        fin       start     l   sd  busy  done
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h00F0, 16'h0000, 16'h0000, 0, 0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h00F0, 16'h00F0, 0, 0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFF0F, 16'h0000, 0, 0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0010, 16'h0000, 0, 0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0060, 16'h0000, 0, 0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0080, 16'h0000, 0, 0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h00F0, 1, 1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            rst       = vecs[i].rst;
            go        = vecs[i].go;
            ack       = vecs[i].ack;
            pe_enable = vecs[i].en;
            finished  = vecs[i].fin;
            tick();
            check($sformatf("v%0d_pe_start", i), 32'(pe_start), 32'(vecs[i].e_start));
            check($sformatf("v%0d_l_step", i), l_step, vecs[i].e_l);
            check($sformatf("v%0d_steps_done", i), steps_done, vecs[i].e_sd);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            check($sformatf("v%0d_timeout", i), 32'(timeout), 32'd0);
        end

        do_run(16'hFFFF, 0, 8, 7, -1);
        do_run(16'hFFFF, 1, 20, 19, -1);
        do_run(16'hFFFF, 2, 20, 19, -1);
        do_run(16'h00F0, 4, 6, 5, -1);
        do_run(16'hFFFF, 3, 3, 2, -1);

        do_run(16'hFFFF, 0, 8, 7, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_pe_start", 32'(pe_start), 32'd0);
        check("rst_mid_l_step", l_step, 32'd0);
        check("rst_mid_steps_done", steps_done, 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        tick();
        check("post_rst_pe_start", 32'(pe_start), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        do_run(16'hFFFF, 0, 8, 7, -1);

`ifdef STEP_TIMEOUT_EN
        begin
            int k;
            do_run(16'hFFFF, 0, 8, 7, 2);
            finished = 16'hFDFF;
            for (k = 1; k <= 60; k++) begin
                tick();
                if (done) begin
                    break;
                end
            end
            check("wd_cycles", 32'(k), 32'(TO));
            check("wd_timeout", 32'(timeout), 32'd1);
            check("wd_steps_done", steps_done, 32'd2);
            check("wd_busy", 32'(busy), 32'd0);
            finished = '0;
            ack      = 1'b1;
            tick();
            ack      = 1'b0;
            check("wd_sticky_after_ack", 32'(timeout), 32'd1);
            go        = 1'b1;
            pe_enable = 16'hFFFF;
            tick();
            go        = 1'b0;
            check("wd_cleared_by_go", 32'(timeout), 32'd0);
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
